// File: rtl/fp_addsub_arbiter_ctrl.sv
// fp_addsub_arbiter_ctrl
// Round-robin front end that shares one combinational fp_adder_subber between
// two requesters. Operands arrive packed (IEEE-754 single or half), are unpacked
// into the adder's sign/exponent/mantissa fields, and results are packed back.
// Zero/Inf/NaN operands are resolved locally because the adder always assumes
// an implicit leading one.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   req_valid[1:0]/req_ready    per-requester request handshake (ready is combinational)
//   req{0,1}_{a,b}              packed operands (half uses bits[15:0])
//   req_op[i], req_mode[i]      0=add/1=sub, 0=half/1=single for requester i
//   dp_*  (out)                 registered adder operand drive
//   dp_*  (in)                  adder result and {ovf, unf, inx} flags
//   resp_valid/resp_ready       tagged response handshake
//   resp_id, resp_result        owning requester, packed result (half zero-extended)
//   resp_flags                  {invalid, overflow, underflow, inexact}
//   busy                        FSM not idle
//   op_count                    completed response handshakes, wraps
module fp_addsub_arbiter_ctrl #(
    parameter int unsigned HP_REBIAS = 112,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    input  logic [1:0]       req_op,
    input  logic [1:0]       req_mode,
    output logic             dp_sign_a,
    output logic             dp_sign_b,
    output logic             dp_operation,
    output logic             dp_mode_fp,
    output logic             dp_round_mode,
    output logic [7:0]       dp_exp_a,
    output logic [7:0]       dp_exp_b,
    output logic [22:0]      dp_mant_a,
    output logic [22:0]      dp_mant_b,
    input  logic             dp_sign,
    input  logic [7:0]       dp_exp,
    input  logic [22:0]      dp_mant,
    input  logic             dp_ovf,
    input  logic             dp_unf,
    input  logic             dp_inx,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [31:0]      resp_result,
    output logic [3:0]       resp_flags,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t state_q, state_d;

    logic        rr_ptr;        // 0: requester 0 preferred
    logic        grant_c, grant_vld_c, accept_c;
    logic [31:0] sel_a_c, sel_b_c;
    logic        sel_op_c, sel_mode_c;
    logic [31:0] unp_a_c, unp_b_c;
    logic [2:0]  cls_a_c, cls_b_c;  // {zero, inf, nan}
    logic        sign_a_c, sign_b_eff_c;
    logic        byp_hit_c, byp_inv_c;
    logic [31:0] byp_res_c;
    logic        byp_hit_q, byp_inv_q, id_q;
    logic [31:0] byp_res_q;
    logic [31:0] pack_res_c;
    logic [3:0]  pack_flags_c;
    logic [4:0]  hexp_c;

    // Single passes through; half is rebiased and left-aligned into 23 bits.
    function automatic logic [31:0] unpack_op(input logic [31:0] x, input logic single);
        if (single) return x;
        return {x[15], 8'(x[14:10]) + 8'(HP_REBIAS), x[9:0], 13'b0};
    endfunction

    // Returns {zero, inf, nan} from the raw encoding; subnormals count as zero.
    function automatic logic [2:0] classify(input logic [31:0] x, input logic single);
        logic zero, special, frac_nz;
        if (single) begin
            zero    = (x[30:23] == 8'h00);
            special = &x[30:23];
            frac_nz = |x[22:0];
        end else begin
            zero    = (x[14:10] == 5'h00);
            special = &x[14:10];
            frac_nz = |x[9:0];
        end
        return {zero, special & ~frac_nz, special & frac_nz};
    endfunction

    // Arbitration: lone requester wins, contention goes to the preferred one.
    always_comb begin
        grant_vld_c = 1'b0;
        grant_c     = 1'b0;
        case (req_valid)
            2'b01:   begin grant_vld_c = 1'b1; grant_c = 1'b0;   end
            2'b10:   begin grant_vld_c = 1'b1; grant_c = 1'b1;   end
            2'b11:   begin grant_vld_c = 1'b1; grant_c = rr_ptr; end
            default: ;
        endcase
    end

    assign accept_c      = (state_q == IDLE) && grant_vld_c;
    assign req_ready     = accept_c ? (grant_c ? 2'b10 : 2'b01) : 2'b00;
    assign dp_round_mode = 1'b0;

    assign sel_a_c    = grant_c ? req1_a : req0_a;
    assign sel_b_c    = grant_c ? req1_b : req0_b;
    assign sel_op_c   = req_op[grant_c];
    assign sel_mode_c = req_mode[grant_c];

    assign unp_a_c      = unpack_op(sel_a_c, sel_mode_c);
    assign unp_b_c      = unpack_op(sel_b_c, sel_mode_c);
    assign cls_a_c      = classify(sel_a_c, sel_mode_c);
    assign cls_b_c      = classify(sel_b_c, sel_mode_c);
    assign sign_a_c     = sel_mode_c ? sel_a_c[31] : sel_a_c[15];
    assign sign_b_eff_c = (sel_mode_c ? sel_b_c[31] : sel_b_c[15]) ^ sel_op_c;

    // Special-operand results the adder cannot produce, in priority order.
    always_comb begin
        byp_hit_c = 1'b0;
        byp_inv_c = 1'b0;
        byp_res_c = '0;
        if (cls_a_c[0] || cls_b_c[0] ||
            (cls_a_c[1] && cls_b_c[1] && (sign_a_c != sign_b_eff_c))) begin
            byp_hit_c = 1'b1;
            byp_inv_c = 1'b1;
            byp_res_c = sel_mode_c ? 32'h7FC0_0000 : 32'h0000_7E00;
        end else if (cls_a_c[1]) begin
            byp_hit_c = 1'b1;
            byp_res_c = sel_mode_c ? {sign_a_c, 8'hFF, 23'b0} : {16'b0, sign_a_c, 5'h1F, 10'b0};
        end else if (cls_b_c[1]) begin
            byp_hit_c = 1'b1;
            byp_res_c = sel_mode_c ? {sign_b_eff_c, 8'hFF, 23'b0} : {16'b0, sign_b_eff_c, 5'h1F, 10'b0};
        end else if (cls_a_c[2] && cls_b_c[2]) begin
            byp_hit_c = 1'b1;
            byp_res_c = sel_mode_c ? {sign_a_c & sign_b_eff_c, 31'b0}
                                   : {16'b0, sign_a_c & sign_b_eff_c, 15'b0};
        end else if (cls_a_c[2]) begin
            byp_hit_c = 1'b1;
            byp_res_c = sel_mode_c ? {sign_b_eff_c, sel_b_c[30:0]} : {16'b0, sign_b_eff_c, sel_b_c[14:0]};
        end else if (cls_b_c[2]) begin
            byp_hit_c = 1'b1;
            byp_res_c = sel_mode_c ? sel_a_c : {16'b0, sel_a_c[15:0]};
        end
    end

    assign hexp_c = 5'(dp_exp - 8'(HP_REBIAS));

    // Pack adder output. A half result whose exponent exceeds the half range is
    // treated as overflow even if the adder did not flag it.
    always_comb begin
        pack_res_c   = {dp_sign, dp_exp, dp_mant};
        pack_flags_c = {1'b0, dp_ovf, dp_unf, dp_inx};
        if (byp_hit_q) begin
            pack_res_c   = byp_res_q;
            pack_flags_c = {byp_inv_q, 3'b000};
        end else if (!dp_mode_fp) begin
            if (dp_ovf || (dp_exp > 8'(HP_REBIAS + 30))) begin
                pack_res_c   = {16'b0, dp_sign, 5'h1F, 10'b0};
                pack_flags_c = {1'b0, 1'b1, dp_unf, dp_inx};
            end else if (dp_exp < 8'(HP_REBIAS + 1)) begin
                pack_res_c   = {16'b0, dp_sign, 15'b0};
                pack_flags_c = {1'b0, dp_ovf, 1'b1, 1'b1};
            end else begin
                pack_res_c   = {16'b0, dp_sign, hexp_c, dp_mant[22:13]};
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            busy    <= (state_d != IDLE);
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept_c) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand capture, bypass result and round-robin pointer on accept
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr       <= 1'b0;
            dp_sign_a    <= 1'b0;
            dp_sign_b    <= 1'b0;
            dp_exp_a     <= '0;
            dp_exp_b     <= '0;
            dp_mant_a    <= '0;
            dp_mant_b    <= '0;
            dp_operation <= 1'b0;
            dp_mode_fp   <= 1'b0;
            byp_hit_q    <= 1'b0;
            byp_inv_q    <= 1'b0;
            byp_res_q    <= '0;
            id_q         <= 1'b0;
        end else if (accept_c) begin
            if (req_valid == 2'b11) rr_ptr <= ~grant_c;
            {dp_sign_a, dp_exp_a, dp_mant_a} <= unp_a_c;
            {dp_sign_b, dp_exp_b, dp_mant_b} <= unp_b_c;
            dp_operation <= sel_op_c;
            dp_mode_fp   <= sel_mode_c;
            byp_hit_q    <= byp_hit_c;
            byp_inv_q    <= byp_inv_c;
            byp_res_q    <= byp_res_c;
            id_q         <= grant_c;
        end
    end

    // Response channel and completion counter
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid  <= 1'b0;
            resp_id     <= 1'b0;
            resp_result <= '0;
            resp_flags  <= '0;
            op_count    <= '0;
        end else if (state_q == EXEC) begin
            resp_valid  <= 1'b1;
            resp_id     <= id_q;
            resp_result <= pack_res_c;
            resp_flags  <= pack_flags_c;
        end else if ((state_q == RESP) && resp_ready) begin
            resp_valid  <= 1'b0;
            op_count    <= op_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fp_addsub_arbiter_ctrl.sv
// Directed testbench for fp_addsub_arbiter_ctrl. The bench stands in for the
// external adder by driving hand-computed dp_* results during EXEC.
module tb_fp_addsub_arbiter_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid, req_ready, req_op, req_mode;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        dp_sign_a, dp_sign_b, dp_operation, dp_mode_fp, dp_round_mode;
    logic [7:0]  dp_exp_a, dp_exp_b, dp_exp;
    logic [22:0] dp_mant_a, dp_mant_b, dp_mant;
    logic        dp_sign, dp_ovf, dp_unf, dp_inx;
    logic        resp_valid, resp_ready, resp_id, busy;
    logic [31:0] resp_result;
    logic [3:0]  resp_flags;
    logic [15:0] op_count;

    int vectors     = 0;
    int miscompares = 0;
    int exp_count   = 0;

    always #5 clk = ~clk;

    fp_addsub_arbiter_ctrl #(.HP_REBIAS(112), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .req_op(req_op), .req_mode(req_mode),
        .dp_sign_a(dp_sign_a), .dp_sign_b(dp_sign_b), .dp_operation(dp_operation),
        .dp_mode_fp(dp_mode_fp), .dp_round_mode(dp_round_mode),
        .dp_exp_a(dp_exp_a), .dp_exp_b(dp_exp_b),
        .dp_mant_a(dp_mant_a), .dp_mant_b(dp_mant_b),
        .dp_sign(dp_sign), .dp_exp(dp_exp), .dp_mant(dp_mant),
        .dp_ovf(dp_ovf), .dp_unf(dp_unf), .dp_inx(dp_inx),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_result(resp_result), .resp_flags(resp_flags),
        .busy(busy), .op_count(op_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        req_valid  = 2'b00;
        resp_ready = 1'b0;
        tick();
        tick();
        rst        = 1'b0;
        exp_count  = 0;
    endtask

    task automatic drive_adder(input logic [31:0] res, input logic [2:0] flags);
        {dp_sign, dp_exp, dp_mant} = res;
        {dp_ovf, dp_unf, dp_inx}   = flags;
    endtask

    // One complete transaction from a single requester, checked at every stage.
    task automatic run_op(input string tag, input logic id,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic op, input logic mode,
                          input logic [31:0] exp_dpa, input logic [31:0] exp_dpb,
                          input logic [31:0] adder_res, input logic [2:0] adder_flags,
                          input logic [31:0] exp_res, input logic [3:0] exp_flags);
        if (id) begin req1_a = a; req1_b = b; end
        else    begin req0_a = a; req0_b = b; end
        req_op[id]   = op;
        req_mode[id] = mode;
        req_valid    = id ? 2'b10 : 2'b01;
        #1;
        check({tag, ".req_ready"}, 32'(req_ready), id ? 32'd2 : 32'd1);
        tick();
        req_valid = 2'b00;
        check({tag, ".busy_exec"}, 32'(busy), 32'd1);
        check({tag, ".dp_a"}, {dp_sign_a, dp_exp_a, dp_mant_a}, exp_dpa);
        check({tag, ".dp_b"}, {dp_sign_b, dp_exp_b, dp_mant_b}, exp_dpb);
        check({tag, ".dp_ctl"}, 32'({dp_operation, dp_mode_fp, dp_round_mode}), 32'({op, mode, 1'b0}));
        check({tag, ".no_early_valid"}, 32'(resp_valid), 32'd0);
        drive_adder(adder_res, adder_flags);
        tick();
        check({tag, ".resp_valid"}, 32'(resp_valid), 32'd1);
        check({tag, ".resp_id"}, 32'(resp_id), 32'(id));
        check({tag, ".resp_result"}, resp_result, exp_res);
        check({tag, ".resp_flags"}, 32'(resp_flags), 32'(exp_flags));
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        exp_count++;
        check({tag, ".valid_drop"}, 32'(resp_valid), 32'd0);
        check({tag, ".op_count"}, 32'(op_count), 32'(exp_count));
        check({tag, ".busy_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 2'b00; req_op = 2'b00; req_mode = 2'b00; resp_ready = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        drive_adder(32'h0, 3'b000);

        do_reset();
        check("reset.resp_valid", 32'(resp_valid), 32'd0);
        check("reset.busy", 32'(busy), 32'd0);
        check("reset.op_count", 32'(op_count), 32'd0);
        check("reset.resp_result", resp_result, 32'h0);
        check("reset.resp_flags", 32'(resp_flags), 32'h0);
        check("reset.dp_a", {dp_sign_a, dp_exp_a, dp_mant_a}, 32'h0);
        check("reset.req_ready", 32'(req_ready), 32'd0);

        // Single 1.0 + 2.0 = 3.0 through the adder
        run_op("sgl_add", 1'b0, 32'h3F80_0000, 32'h4000_0000, 1'b0, 1'b1,
               32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 3'b000, 32'h4040_0000, 4'b0000);
        // Half 1.0 - 1.0: adder returns zero exponent, below half range
        run_op("hlf_sub_zero", 1'b1, 32'h3C00, 32'h3C00, 1'b1, 1'b0,
               32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000, 3'b000, 32'h0000_0000, 4'b0011);
        // Half Inf - Inf -> qNaN, adder output ignored
        run_op("hlf_inf_inf", 1'b1, 32'h7C00, 32'h7C00, 1'b1, 1'b0,
               32'h4780_0000, 32'h4780_0000, 32'h1234_5678, 3'b111, 32'h0000_7E00, 4'b1000);
        // Half max + max overflows to Inf
        run_op("hlf_ovf", 1'b0, 32'h7BFF, 32'h7BFF, 1'b0, 1'b0,
               32'h477F_E000, 32'h477F_E000, 32'h47FF_E000, 3'b101, 32'h0000_7C00, 4'b0101);
        // Half 1.0 + 1.0 = 2.0 through the normal half pack
        run_op("hlf_add", 1'b0, 32'h3C00, 32'h3C00, 1'b0, 1'b0,
               32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 3'b000, 32'h0000_4000, 4'b0000);
        // Single 0 - (-5.0) = +5.0 bypass
        run_op("sgl_zero_a", 1'b0, 32'h0000_0000, 32'hC0A0_0000, 1'b1, 1'b1,
               32'h0000_0000, 32'hC0A0_0000, 32'h1234_5678, 3'b111, 32'h40A0_0000, 4'b0000);
        // Single NaN operand -> canonical qNaN
        run_op("sgl_nan", 1'b1, 32'h7F80_0001, 32'h3F80_0000, 1'b0, 1'b1,
               32'h7F80_0001, 32'h3F80_0000, 32'h1234_5678, 3'b111, 32'h7FC0_0000, 4'b1000);
        // Single -Inf + 1.0 -> -Inf
        run_op("sgl_ninf", 1'b0, 32'hFF80_0000, 32'h3F80_0000, 1'b0, 1'b1,
               32'hFF80_0000, 32'h3F80_0000, 32'h1234_5678, 3'b111, 32'hFF80_0000, 4'b0000);
        // Half -0 - (+0) -> -0
        run_op("hlf_zero_zero", 1'b1, 32'h8000, 32'h0000, 1'b1, 1'b0,
               32'hB800_0000, 32'h3800_0000, 32'h1234_5678, 3'b111, 32'h0000_8000, 4'b0000);

        // Contention: both requesters valid throughout, grants alternate from requester 0
        do_reset();
        req0_a = 32'h3F80_0000; req0_b = 32'h4000_0000;
        req1_a = 32'h3F80_0000; req1_b = 32'h4000_0000;
        req_op = 2'b00; req_mode = 2'b11;
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("rr.req_ready", 32'(req_ready), (k % 2 == 1) ? 32'd2 : 32'd1);
            tick();
            check("rr.no_ready_exec", 32'(req_ready), 32'd0);
            drive_adder(32'h4040_0000, 3'b000);
            tick();
            check("rr.resp_id", 32'(resp_id), 32'(k % 2));
            for (int h = 0; h < 3; h++) begin
                tick();
                check("rr.hold_valid", 32'(resp_valid), 32'd1);
                check("rr.hold_result", resp_result, 32'h4040_0000);
                check("rr.hold_no_ready", 32'(req_ready), 32'd0);
            end
            resp_ready = 1'b1;
            tick();
            resp_ready = 1'b0;
            exp_count++;
            check("rr.op_count", 32'(op_count), 32'(exp_count));
        end
        req_valid = 2'b00;
        tick();

        // Reset while EXEC: operation dropped, counter cleared
        req0_a = 32'h3F80_0000; req0_b = 32'h4000_0000; req_mode = 2'b01;
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        check("midrst.busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        check("midrst.resp_valid", 32'(resp_valid), 32'd0);
        check("midrst.busy", 32'(busy), 32'd0);
        check("midrst.op_count", 32'(op_count), 32'd0);
        rst = 1'b0;
        tick();
        tick();
        check("midrst.no_resp", 32'(resp_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fp_addsub_arbiter_ctrl.md
Name: fp_addsub_arbiter_ctrl

Overview:
- Shares one combinational fp_adder_subber datapath between two requesters using round-robin arbitration.
- Accepts packed IEEE-754 operands in single or half precision and unpacks them into the adder's sign/exponent/mantissa fields.
- Bypasses zero, Inf and NaN cases that the adder cannot handle, because the adder always assumes an implicit leading 1.
- Registers and packs the result, then returns it on a tagged response channel with valid/ready handshake.

Parameters:
- HP_REBIAS, 112, added to half exponent to form single-biased exponent (127-15).
- CNT_W, 16, width of completed-operation counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  2  per-requester request valid (bit i = requester i)
- req_ready  out  2  per-requester accept; combinational
- req0_a, req0_b  in  32  requester 0 operands; half uses bits[15:0]
- req1_a, req1_b  in  32  requester 1 operands
- req_op  in  2  per-requester operation: 0=add, 1=sub
- req_mode  in  2  per-requester precision: 0=half, 1=single
- dp_sign_a, dp_sign_b, dp_operation, dp_mode_fp, dp_round_mode  out  1  adder drive; round_mode fixed 0
- dp_exp_a, dp_exp_b  out  8  adder exponents
- dp_mant_a, dp_mant_b  out  23  adder mantissas
- dp_sign  in  1  adder result_sign
- dp_exp  in  8  adder result_exp
- dp_mant  in  23  adder result_mant
- dp_ovf, dp_unf, dp_inx  in  1  adder flags
- resp_valid  out  1  response valid
- resp_ready  in  1  response accept
- resp_id  out  1  requester the response belongs to
- resp_result  out  32  packed result; half results zero-extended
- resp_flags  out  4  {invalid, overflow, underflow, inexact}
- busy  out  1  state != IDLE
- op_count  out  CNT_W  number of completed response handshakes; wraps

Behaviour:
- FSM states: IDLE, EXEC, RESP. Reset puts the FSM in IDLE and clears resp_valid, resp_id, resp_result, resp_flags, op_count, and all dp_* operand registers to 0. The round-robin pointer is reset to "requester 0 preferred".
- Arbitration in IDLE:
  - Only one valid request: grant it.
  - Both valid: grant the preferred requester; the pointer then prefers the other one.
  - req_ready[i] = (state==IDLE) && grant==i; at most one bit is high. The handshake completes on that cycle and the FSM goes to EXEC.
- Unpack on accept into registers:
  - Single precision: sign = a[31], exp = a[30:23], mant = a[22:0].
  - Half precision: sign = a[15], exp = a[14:10] + HP_REBIAS, mant = {a[9:0], 13'b0}.
  - Same rules for b. dp_operation and dp_mode_fp come from the granted requester.
- Classification of each operand:
  - Zero: raw exp field == 0. Subnormals are flushed to zero.
  - Special: raw exp field all ones (0xFF single, 0x1F half).
  - NaN: special with nonzero fraction.
- Bypass result, computed at accept, takes priority over the adder. b's sign is inverted when op=1.
  - Any NaN, or Inf minus Inf in the effective operation: canonical qNaN (0x7FC00000 single, 0x7E00 half), invalid=1.
  - Any Inf otherwise: that Inf, with sign set by the Inf operand.
  - Both zero: zero, sign = sign_a AND effective sign_b.
  - One zero: the other operand, with the effective sign.
- EXEC (exactly 1 cycle): dp_* are stable from registers. At the end of EXEC, capture either the bypass result or the packed adder output into resp_*, then go to RESP.
- Packing the adder output:
  - Single precision: {dp_sign, dp_exp, dp_mant}.
  - Half precision, dp_ovf=1: Inf.
  - Half precision, dp_exp < 113: signed zero, underflow=1, inexact=1.
  - Half precision otherwise: {dp_sign, dp_exp-112 [4:0], dp_mant[22:13]}.
  - Flags come from dp_* except as overridden above.
- RESP: resp_valid=1 and holds resp_* stable until resp_ready. On the handshake: op_count+1, resp_valid drops the next cycle, FSM returns to IDLE.
- Latency: request accepted at cycle T gives resp_valid at T+2. Peak throughput is 1 operation per 3 cycles.
- Requests are not accepted while in EXEC or RESP. A requester must hold its valid and data stable until ready.
- Reset mid-operation: the in-flight operation is dropped, no response is produced, and the counter is cleared.
- op_count wraps from all-ones to 0.

Test Plan:
- Single add, requester 0, a=0x3F800000, b=0x40000000 → resp at T+2: result 0x40400000, id=0, flags 0000.
- Half sub, requester 1, a=0x3C00, b=0x3C00 → result 0x00000000, id=1; a=0x7C00, b=0x7C00, op=sub → result 0x00007E00, invalid=1.
- Both requesters valid continuously for 4 ops → grants alternate 0,1,0,1 after reset; hold resp_ready low 3 cycles → resp_result stable, no new req_ready.
- Half overflow: a=0x7BFF, b=0x7BFF add → result 0x00007C00, overflow=1.
- Zero operand: single a=0x00000000, b=0xC0A00000, op=sub → result 0x40A00000; NaN a=0x7F800001 → result 0x7FC00000, invalid=1.
- Assert rst during EXEC → no resp_valid, busy=0, op_count=0 on the next cycle.
